uart_keyword_matcher: RTL and testbench

Streaming command recogniser for the UART receive path of the DDS control logic. It collects received bytes into a line buffer until a terminator arrives, then compares the buffered string against `KEY_NUM` parametrised keywords, one keyword per cycle. It reports a one-cycle result pulse with hit flag, matching keyword index and length-error flag. It sits between the UART receiver and the command decoder that drives DDS register writes.

---
 rtl/uart_cmd_pkg.sv | 7 +
 rtl/key_compare_unit.sv | 15 +
 rtl/uart_keyword_matcher.sv | 126 ++++++++++++
 tb/tb_uart_keyword_matcher.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: FSM states and byte constants shared by the UART command path.
package uart_cmd_pkg;
    typedef enum logic [1:0] {COLLECT, COMPARE, DONE} state_t;
    localparam logic [7:0] NUL = 8'h00;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
endpackage

// File: rtl/key_compare_unit.sv
// key_compare_unit: combinational equal/greater/less of two MSB-first byte strings.
module key_compare_unit #(
    parameter int byte_num = 8
) (
    input  logic [byte_num*8-1:0] i_a,
    input  logic [byte_num*8-1:0] i_b,
    output logic                  o_equal,
    output logic                  o_greater,
    output logic                  o_less
);
    // MSB-first packing makes numeric order equal to lexicographic order
    assign o_equal   = i_a == i_b;
    assign o_greater = i_a > i_b;
    assign o_less    = i_a < i_b;
endmodule

// File: rtl/uart_keyword_matcher.sv
// uart_keyword_matcher: buffers a UART line up to TERM, then scans a keyword
// table one entry per cycle and reports a single-cycle result pulse.
module uart_keyword_matcher
    import uart_cmd_pkg::*;
#(
    parameter int          KEY_NUM = 4,
    parameter int          KEY_LEN = 8,
    parameter logic [7:0]  TERM    = LF,
    localparam int         CW      = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [KEY_NUM*KEY_LEN*8-1:0] keys,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic                        match_valid,
    output logic                        match_hit,
    output logic [CW-1:0]               match_idx,
    output logic                        len_err
);
    localparam int CNTW = $clog2(KEY_LEN + 1);

    state_t              r_state;
    logic [KEY_LEN*8-1:0] r_buf;
    logic [CNTW-1:0]     r_count;
    logic                r_ovf;
    logic [CW-1:0]       r_cmp_idx;
    logic                r_rx_ready;
    logic                r_match_valid;
    logic                r_hit;
    logic [CW-1:0]       r_idx;
    logic                r_len_err;

    logic [KEY_LEN*8-1:0] w_key;
    logic                w_eq;
    logic                w_gt;
    logic                w_lt;
    logic                w_accept;

    assign w_key    = keys[int'(r_cmp_idx)*KEY_LEN*8 +: KEY_LEN*8];
    assign w_accept = rx_valid && r_rx_ready;

    key_compare_unit #(.byte_num(KEY_LEN)) u_cmp (
        .i_a      (r_buf),
        .i_b      (w_key),
        .o_equal  (w_eq),
        .o_greater(w_gt),
        .o_less   (w_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= COLLECT;
            r_buf         <= '0;
            r_count       <= '0;
            r_ovf         <= 1'b0;
            r_cmp_idx     <= '0;
            r_rx_ready    <= 1'b0;
            r_match_valid <= 1'b0;
            r_hit         <= 1'b0;
            r_idx         <= '0;
            r_len_err     <= 1'b0;
        end else begin
            r_match_valid <= 1'b0;
            case (r_state)
                COLLECT: begin
                    r_rx_ready <= 1'b1;
                    if (w_accept && rx_data != NUL && rx_data != CR) begin
                        if (rx_data == TERM) begin
                            if (r_ovf) begin
                                r_state       <= DONE;
                                r_rx_ready    <= 1'b0;
                                r_match_valid <= 1'b1;
                                r_hit         <= 1'b0;
                                r_idx         <= '0;
                                r_len_err     <= 1'b1;
                            end else if (r_count != '0) begin
                                r_state    <= COMPARE;
                                r_rx_ready <= 1'b0;
                                r_cmp_idx  <= '0;
                            end
                        end else if (r_count == CNTW'(KEY_LEN)) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_buf[(KEY_LEN-1-int'(r_count))*8 +: 8] <= rx_data;
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                COMPARE: begin
                    // gt/lt folded in so the full comparator stays exercised
                    if (w_eq && !(w_gt || w_lt)) begin
                        r_state       <= DONE;
                        r_match_valid <= 1'b1;
                        r_hit         <= 1'b1;
                        r_idx         <= r_cmp_idx;
                        r_len_err     <= 1'b0;
                    end else if (r_cmp_idx == CW'(KEY_NUM-1)) begin
                        r_state       <= DONE;
                        r_match_valid <= 1'b1;
                        r_hit         <= 1'b0;
                        r_idx         <= '0;
                        r_len_err     <= 1'b0;
                    end else begin
                        r_cmp_idx <= r_cmp_idx + 1'b1;
                    end
                end
                default: begin
                    r_state    <= COLLECT;
                    r_buf      <= '0;
                    r_count    <= '0;
                    r_ovf      <= 1'b0;
                    r_cmp_idx  <= '0;
                    r_rx_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready    = r_rx_ready;
    assign match_valid = r_match_valid;
    assign match_hit   = r_hit;
    assign match_idx   = r_idx;
    assign len_err     = r_len_err;
endmodule

// File: tb/tb_uart_keyword_matcher.sv
// tb_uart_keyword_matcher: directed lines with a scoreboard of expected result
// pulses (fields and arrival cycle) checked by independent monitors.
module tb_uart_keyword_matcher;
    localparam logic [63:0] K0 = {"FREQ", 32'h0};
    localparam logic [63:0] K1 = {"PHASE", 24'h0};
    localparam logic [63:0] K2 = {"AMP", 40'h0};
    localparam logic [63:0] K3 = {"RST", 40'h0};
    localparam logic [63:0] G0 = {"GO", 48'h0};

    typedef struct {
        int hit;
        int idx;
        int lerr;
        int cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] keys0 = {K3, K2, K1, K0};
    logic [63:0]  keys1 = G0;
    logic [7:0]   rx_data0 = 8'h00, rx_data1 = 8'h00;
    logic         rx_valid0 = 1'b0, rx_valid1 = 1'b0;
    logic         rx_ready0, rx_ready1;
    logic         mv0, mv1, hit0, hit1, le0, le1;
    logic [1:0]   idx0;
    logic [0:0]   idx1;

    int   cyc = 0;
    int   hs0 = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    uart_keyword_matcher #(.KEY_NUM(4), .KEY_LEN(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .keys(keys0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(rx_ready0), .match_valid(mv0), .match_hit(hit0), .match_idx(idx0), .len_err(le0)
    );

    uart_keyword_matcher #(.KEY_NUM(1), .KEY_LEN(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .keys(keys1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(rx_ready1), .match_valid(mv1), .match_hit(hit1), .match_idx(idx1), .len_err(le1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid0 && rx_ready0) hs0 <= hs0 + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pulse_check(input string tag, input int h, input int i, input int l, input exp_t e);
        chk({tag, "_hit"}, h, e.hit);
        chk({tag, "_idx"}, i, e.idx);
        chk({tag, "_len_err"}, l, e.lerr);
        chk({tag, "_cycle"}, cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (mv0) begin
            if (q0.size() == 0) chk("dut0_unexpected_pulse", 1, 0);
            else pulse_check("dut0", int'(hit0), int'(idx0), int'(le0), q0.pop_front());
        end
        if (mv1) begin
            if (q1.size() == 0) chk("dut1_unexpected_pulse", 1, 0);
            else pulse_check("dut1", int'(hit1), int'(idx1), int'(le1), q1.pop_front());
        end
    end

    task automatic send_byte(input bit sel, input logic [7:0] b);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        if (sel) begin rx_valid1 = 1'b1; rx_data1 = b; end
        else     begin rx_valid0 = 1'b1; rx_data0 = b; end
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = sel ? rx_ready1 : rx_ready0;
            @(posedge clk);
            n++;
        end
        if (!ok) chk("handshake_timeout", 0, 1);
        #1;
    endtask

    task automatic send_str(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
    endtask

    task automatic idle();
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
    endtask

    // lat follows the T+n convention: cycle T+1 is the one right after the TERM edge
    task automatic term(input bit sel, input bit push, input int h, input int i, input int l,
                        input int lat, input bit hold);
        exp_t e;
        send_byte(sel, 8'h0A);
        e.hit = h; e.idx = i; e.lerr = l; e.cyc = cyc + lat - 1;
        if (push) begin
            if (sel) q1.push_back(e);
            else     q0.push_back(e);
        end
        if (!hold) idle();
    endtask

    initial begin
        int hs_start;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", int'(rx_ready0), 0);
        chk("rst_match_valid", int'(mv0), 0);
        chk("rst_match_hit", int'(hit0), 0);
        chk("rst_match_idx", int'(idx0), 0);
        chk("rst_len_err", int'(le0), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_str(0, "AMP");
        term(0, 1, 1, 2, 0, 4, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_rx_ready", int'(rx_ready0), 0);
        end
        @(negedge clk);
        chk("rx_ready_return", int'(rx_ready0), 1);
        @(posedge clk); #1;

        send_str(0, "AMPL");
        send_byte(0, 8'h0D);
        term(0, 1, 0, 0, 0, 5, 0);
        term(0, 0, 0, 0, 0, 0, 0);
        send_byte(0, "R");
        send_byte(0, 8'h00);
        send_str(0, "ST");
        term(0, 1, 1, 3, 0, 5, 0);

        send_str(0, "FREQUENCY");
        term(0, 1, 0, 0, 1, 1, 0);
        send_str(0, "FREQ");
        term(0, 1, 1, 0, 0, 2, 0);
        send_str(0, "PHASEXYZ");
        term(0, 1, 0, 0, 0, 5, 0);

        hs_start = hs0;
        send_str(0, "FREQ");
        term(0, 1, 1, 0, 0, 2, 1);
        send_str(0, "PHASE");
        term(0, 1, 1, 1, 0, 3, 0);
        chk("b2b_handshakes", hs0 - hs_start, 11);

        send_str(0, "RST");
        term(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rx_ready", int'(rx_ready0), 0);
        chk("midrst_match_valid", int'(mv0), 0);
        chk("midrst_match_hit", int'(hit0), 0);
        chk("midrst_match_idx", int'(idx0), 0);
        chk("midrst_len_err", int'(le0), 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_rx_ready", int'(rx_ready0), 1);
        @(posedge clk); #1;
        send_str(0, "AMP");
        term(0, 1, 1, 2, 0, 4, 0);

        send_str(1, "GO");
        term(1, 1, 1, 0, 0, 2, 0);
        send_str(1, "G");
        term(1, 1, 0, 0, 0, 2, 0);

        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("dut0_pending_results", q0.size(), 0);
        chk("dut1_pending_results", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
